d_input_debouncer: RTL and testbench

//  Upstream conditioning stage for the JK-based D flip-flop chain.

---
 rtl/d_input_debouncer.sv | 160 ++++++++++++++++
 tb/tb_d_input_debouncer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/d_input_debouncer.sv
// ---------------------------------------------------------------------------
// d_input_debouncer
//
// Conditions an asynchronous, bouncy raw level (switch or pin) for the
// JK-based D flip-flop chain. raw_in passes through a two-flop synchroniser
// and then a four-state qualification FSM. A new level is accepted only after
// STABLE_CYCLES consecutive synchronised samples agree. The accepted level
// drives d_out, and the FSM emits one-cycle rise/fall strobes for downstream
// counters.
//
// Parameters
//   STABLE_CYCLES : consecutive synced samples needed to accept a level (>= 2)
//   CNT_W         : stability counter width (STABLE_CYCLES-1 must fit)
//
// Ports
//   clk        : rising-edge clock
//   reset      : asynchronous, active-low reset
//   raw_in     : asynchronous raw level, may bounce
//   d_out      : debounced level, registered
//   rise_pulse : one-cycle strobe after d_out goes 0->1
//   fall_pulse : one-cycle strobe after d_out goes 1->0
//   busy       : high while a candidate level change is being qualified
//
// Every output is driven directly by a flop. There is no combinational path
// from raw_in to any output.
// ---------------------------------------------------------------------------
module d_input_debouncer #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic d_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE_LO = 2'b00,
    WAIT_HI = 2'b01,
    IDLE_HI = 2'b10,
    WAIT_LO = 2'b11
  } state_t;

  // The counter value on the sample that completes qualification.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync0_q;
  logic             sync1_q;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             d_out_q;
  logic             rise_q;
  logic             fall_q;
  logic             busy_q;

  // Two-flop synchroniser that brings raw_in into the clk domain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
    end else begin
      sync0_q <= raw_in;
      sync1_q <= sync0_q;
    end
  end

  // Qualification FSM. The state register, stability counter and all
  // registered outputs are updated here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE_LO;
      cnt_q   <= CNT_ZERO;
      d_out_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      // Strobes live for exactly one cycle. They are raised only by the
      // accepting branches below.
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        IDLE_LO: begin
          if (sync1_q) begin
            state_q <= WAIT_HI;
            cnt_q   <= CNT_ONE;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE_LO;
            cnt_q   <= CNT_ZERO;
            busy_q  <= 1'b0;
          end
        end
        WAIT_HI: begin
          if (!sync1_q) begin
            // Bounce back to the old level: restart from scratch.
            state_q <= IDLE_LO;
            cnt_q   <= CNT_ZERO;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE_HI;
            cnt_q   <= CNT_ZERO;
            d_out_q <= 1'b1;
            rise_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q <= WAIT_HI;
            cnt_q   <= cnt_q + CNT_ONE;
            busy_q  <= 1'b1;
          end
        end
        IDLE_HI: begin
          if (!sync1_q) begin
            state_q <= WAIT_LO;
            cnt_q   <= CNT_ONE;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE_HI;
            cnt_q   <= CNT_ZERO;
            busy_q  <= 1'b0;
          end
        end
        WAIT_LO: begin
          if (sync1_q) begin
            state_q <= IDLE_HI;
            cnt_q   <= CNT_ZERO;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE_LO;
            cnt_q   <= CNT_ZERO;
            d_out_q <= 1'b0;
            fall_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q <= WAIT_LO;
            cnt_q   <= cnt_q + CNT_ONE;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          // Recover from a corrupted state register. d_out holds its value.
          state_q <= IDLE_LO;
          cnt_q   <= CNT_ZERO;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign d_out      = d_out_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_d_input_debouncer.sv
// ---------------------------------------------------------------------------
// Self-checking bench for d_input_debouncer with STABLE_CYCLES=4.
//
// The reference model is a run-length view of the behaviour. It counts how
// many consecutive synchronised samples differ from the current debounced
// level. When that run reaches STABLE_CYCLES, the model flips the level and
// raises a strobe. The model is busy whenever a run is in progress.
// ---------------------------------------------------------------------------
module tb_d_input_debouncer;

  localparam int STABLE = 4;

  logic clk    = 1'b0;
  logic reset  = 1'b0;
  logic raw_in = 1'b0;
  logic d_out;
  logic rise_pulse;
  logic fall_pulse;
  logic busy;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit m_s0, m_s1, m_d, m_rise, m_fall, m_busy;
  int m_run;

  d_input_debouncer #(
    .STABLE_CYCLES(STABLE),
    .CNT_W        (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .raw_in    (raw_in),
    .d_out     (d_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_s0 = 1'b0; m_s1 = 1'b0; m_d = 1'b0;
    m_rise = 1'b0; m_fall = 1'b0; m_busy = 1'b0; m_run = 0;
  endtask

  // One clock edge of the model; v is the raw level sampled at that edge.
  task automatic model_edge(input bit v);
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (m_s1 != m_d) begin
      m_run++;
      if (m_run >= STABLE) begin
        m_d    = m_s1;
        m_rise = m_s1;
        m_fall = !m_s1;
        m_run  = 0;
      end
    end else begin
      m_run = 0;
    end
    m_busy = (m_run != 0);
    m_s1 = m_s0;
    m_s0 = v;
  endtask

  // Drive raw_in on the falling edge, advance one rising edge, then settle.
  task automatic cycle(input bit v);
    @(negedge clk);
    raw_in = v;
    @(posedge clk);
    if (!reset) model_reset();
    else        model_edge(v);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(i[0]);
      checks++;
      if ({d_out, rise_pulse, fall_pulse, busy} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_hold cyc %0d got %b expected 0000", i,
                 {d_out, rise_pulse, fall_pulse, busy});
      end
    end
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0);
      checks++;
      if ({d_out, rise_pulse, fall_pulse, busy} !== {m_d, m_rise, m_fall, m_busy}
          || d_out !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cyc %0d got %b expected 0000", i,
                 {d_out, rise_pulse, fall_pulse, busy});
      end
    end
  endtask

  task automatic test_clean_step();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1);
      checks++;
      if ({d_out, rise_pulse, fall_pulse, busy} !==
          {(i >= 5), (i == 5), 1'b0, (i >= 2 && i <= 4)}) begin
        errors++;
        $display("FAIL clean_step edge t0+%0d got %b expected %b", i,
                 {d_out, rise_pulse, fall_pulse, busy},
                 {(i >= 5), (i == 5), 1'b0, (i >= 2 && i <= 4)});
      end
      checks++;
      if ({d_out, rise_pulse, fall_pulse, busy} !== {m_d, m_rise, m_fall, m_busy}) begin
        errors++;
        $display("FAIL clean_step_model edge %0d got %b expected %b", i,
                 {d_out, rise_pulse, fall_pulse, busy}, {m_d, m_rise, m_fall, m_busy});
      end
    end
  endtask

  task automatic test_falling_edge();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0);
      checks++;
      if ({d_out, rise_pulse, fall_pulse, busy} !==
          {(i < 5), 1'b0, (i == 5), (i >= 2 && i <= 4)}) begin
        errors++;
        $display("FAIL falling_edge edge t0+%0d got %b expected %b", i,
                 {d_out, rise_pulse, fall_pulse, busy},
                 {(i < 5), 1'b0, (i == 5), (i >= 2 && i <= 4)});
      end
    end
  endtask

  task automatic test_bounce();
    bit pat [13] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                     1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    int rises = 0;
    int rise_at = -1;
    for (int i = 0; i < 13; i++) begin
      cycle(pat[i]);
      if (rise_pulse === 1'b1) begin
        rises++;
        rise_at = i;
      end
      checks++;
      if ({d_out, rise_pulse, fall_pulse, busy} !== {m_d, m_rise, m_fall, m_busy}) begin
        errors++;
        $display("FAIL bounce_model cyc %0d got %b expected %b", i,
                 {d_out, rise_pulse, fall_pulse, busy}, {m_d, m_rise, m_fall, m_busy});
      end
    end
    checks++;
    if (rises != 1 || rise_at != 8) begin
      errors++;
      $display("FAIL bounce_single_rise got %0d rises at cyc %0d expected 1 at cyc 8",
               rises, rise_at);
    end
  endtask

  task automatic test_short_glitch();
    for (int i = 0; i < 13; i++) begin
      cycle(i < 3);
      checks++;
      if (d_out !== 1'b0 || rise_pulse !== 1'b0 || fall_pulse !== 1'b0 ||
          busy !== m_busy) begin
        errors++;
        $display("FAIL short_glitch cyc %0d got %b expected %b", i,
                 {d_out, rise_pulse, fall_pulse, busy}, {3'b000, m_busy});
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_busy_idle got %b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid_wait();
    for (int i = 0; i < 4; i++) cycle(1'b1);
    checks++;
    if (busy !== 1'b1 || d_out !== 1'b0) begin
      errors++;
      $display("FAIL mid_wait_pre got busy %b d_out %b expected busy 1 d_out 0", busy, d_out);
    end
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({d_out, rise_pulse, fall_pulse, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset got %b expected 0000", {d_out, rise_pulse, fall_pulse, busy});
    end
    cycle(1'b1);
    cycle(1'b1);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1);
      checks++;
      if ({d_out, rise_pulse, fall_pulse, busy} !==
          {(i >= 5), (i == 5), 1'b0, (i >= 2 && i <= 4)}) begin
        errors++;
        $display("FAIL requalify edge t0+%0d got %b expected %b", i,
                 {d_out, rise_pulse, fall_pulse, busy},
                 {(i >= 5), (i == 5), 1'b0, (i >= 2 && i <= 4)});
      end
    end
  endtask

  task automatic test_random();
    bit lvl = 1'b0;
    int left = 0;
    for (int i = 0; i < 400; i++) begin
      if (left == 0) begin
        lvl  = ~lvl;
        left = $urandom_range(1, 7);
      end
      left--;
      cycle(lvl);
      checks++;
      if ({d_out, rise_pulse, fall_pulse, busy} !== {m_d, m_rise, m_fall, m_busy} ||
          (rise_pulse === 1'b1 && fall_pulse === 1'b1)) begin
        errors++;
        $display("FAIL random cyc %0d got %b expected %b", i,
                 {d_out, rise_pulse, fall_pulse, busy}, {m_d, m_rise, m_fall, m_busy});
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_step();
    test_falling_edge();
    test_bounce();
    for (int i = 0; i < 10; i++) cycle(1'b0);
    checks++;
    if (d_out !== 1'b0 || d_out !== m_d) begin
      errors++;
      $display("FAIL settle_low got %b expected 0", d_out);
    end
    test_short_glitch();
    test_reset_mid_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
